avr_progmem_boot: RTL and testbench

Program-memory responder for the AVR core's instruction fetch port (pc in, ir out), with an on-chip word RAM. After reset it copies the program image from an external SPI NOR flash (READ 0x03) into that RAM while holding `locked` low, so the core is stalled. Once the copy completes it raises `locked` and serves one instruction word per clock. It sits between the core, the board flash pins and the PLL-lock logic; the external `pll_locked` is ANDed in.

---
 rtl/avr_progmem_boot_if.sv | 21 ++
 rtl/avr_progmem_boot.sv | 166 ++++++++++++++++
 tb/tb_avr_progmem_boot.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avr_progmem_boot_if.sv
// Core fetch port plus SPI NOR flash pins of the boot-loading program memory.
// Fetch contract: while locked is high, ir holds mem[pc] one clock after pc; low locked means stall.
interface avr_progmem_boot_if;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        locked;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;

    modport master (
        output pc, spi_miso,
        input  ir, locked, spi_cs_n, spi_sck, spi_mosi
    );

    modport slave (
        input  pc, spi_miso,
        output ir, locked, spi_cs_n, spi_sck, spi_mosi
    );
endinterface

// File: rtl/avr_progmem_boot.sv
// AVR program memory: copies the image from SPI NOR flash (READ 0x03) after reset,
// then serves one instruction word per clock to the core.
module avr_progmem_boot #(
    parameter int          AW         = 14,
    parameter int          WORDS      = 16384,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          DIV        = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pll_locked,
    avr_progmem_boot_if.slave bus,
    output logic              busy,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {S_WAIT = 2'd0, S_CMD = 2'd1, S_DATA = 2'd2, S_DONE = 2'd3} state_e;

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = $clog2(2 * DIV + 1);
    localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic            sck_q, sck_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic [5:0]      bit_q, bit_d;
    logic [31:0]     tx_q, tx_d;
    logic [14:0]     rx_q, rx_d;
    logic [WW-1:0]   word_q, word_d;
    logic            last_q, last_d;
    logic            wr_en_q, wr_en_d;
    logic [WW-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]     wr_data_q, wr_data_d;
    logic [15:0]     ir_q;
    logic [15:0]     mem [2**AW];

    logic level_end, rise, fall;

    assign level_end = (div_q == DW'(DIV - 1));
    assign rise      = level_end & ~sck_q;
    assign fall      = level_end & sck_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_WAIT;
            div_q     <= '0;
            sck_q     <= 1'b0;
            guard_q   <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sck_q     <= sck_d;
            guard_q   <= guard_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            word_q    <= word_d;
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        sck_d     = sck_q;
        guard_d   = guard_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        word_d    = word_q;
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_WAIT: begin
                div_d = '0;
                sck_d = 1'b0;
                if (!pll_locked) begin
                    guard_d = '0;
                end else if (guard_q == GW'(2 * DIV)) begin
                    state_d = S_CMD;
                    guard_d = '0;
                    bit_d   = '0;
                    tx_d    = {8'h03, FLASH_BASE};
                end else begin
                    guard_d = guard_q + 1'b1;
                end
            end
            S_CMD, S_DATA: begin
                if (!pll_locked) begin
                    // Losing the clock source mid-copy is handled like a reset.
                    state_d = S_WAIT;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    guard_d = '0;
                end else begin
                    div_d = level_end ? '0 : DW'(div_q + 1'b1);
                    if (level_end) sck_d = ~sck_q;
                    if (state_q == S_CMD && fall) begin
                        tx_d  = {tx_q[30:0], 1'b0};
                        bit_d = bit_q + 1'b1;
                        if (bit_q == 6'd31) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                            word_d  = '0;
                            last_d  = 1'b0;
                        end
                    end
                    if (state_q == S_DATA && rise) begin
                        rx_d  = {rx_q[13:0], bus.spi_miso};
                        bit_d = bit_q + 1'b1;
                        if (bit_q[3:0] == 4'd15) begin
                            // First byte received is the low byte of the word.
                            wr_en_d   = 1'b1;
                            wr_data_d = {rx_q[6:0], bus.spi_miso, rx_q[14:7]};
                            wr_addr_d = word_q;
                            word_d    = word_q + 1'b1;
                            bit_d     = '0;
                            if (word_q == WW'(WORDS - 1)) last_d = 1'b1;
                        end
                    end
                    if (state_q == S_DATA && fall && last_q) begin
                        state_d = S_DONE;
                        sck_d   = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en_q) mem[AW'(wr_addr_q)] <= wr_data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) ir_q <= '0;
        else if (state_q == S_DONE) ir_q <= mem[bus.pc[AW-1:0]];
        else ir_q <= '0;
    end

    if (AW < 16) begin : g_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = ^bus.pc[15:AW];
    end

    assign busy         = (state_q == S_CMD) || (state_q == S_DATA);
    assign bus.spi_cs_n = ~busy;
    assign bus.spi_sck  = sck_q;
    assign bus.spi_mosi = (state_q == S_CMD) ? tx_q[31] : 1'b0;
    assign bus.locked   = (state_q == S_DONE) & pll_locked;
    assign bus.ir       = ir_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_avr_progmem_boot.sv
// Bench for avr_progmem_boot: two instances (DIV=1/WORDS=4 and DIV=3/WORDS=8 at a non-zero
// flash base) against a pin-level SPI flash model and a word-image reference model.
module tb_avr_progmem_boot;
  localparam int NI = 2;
  localparam int AW = 14;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] exp;
  } vec_t;

  logic clock;
  logic [NI-1:0] rst, pll, locked, cs_n, sck, mosi, miso, busy;
  logic [NI-1:0][15:0] pc, ir;
  logic [NI-1:0][1:0] dbg;

  logic [7:0] img [NI][16];
  int rises [NI];
  int lvl_len [NI];
  int lvl_bad [NI];
  int mosi_bad [NI];
  int sck_bad [NI];
  int cs_falls [NI];
  logic [31:0] cmd [NI];
  logic [NI-1:0] cs_prev = '1;
  logic [NI-1:0] sck_prev = '0;
  int d_bit;
  logic [7:0] fbyte;

  int checks = 0;
  int errors = 0;

  avr_progmem_boot_if bus0();
  avr_progmem_boot_if bus1();

  avr_progmem_boot #(.AW(AW), .WORDS(4), .FLASH_BASE(24'h000000), .DIV(1)) dut0 (
    .clock(clock), .reset(rst[0]), .pll_locked(pll[0]), .bus(bus0),
    .busy(busy[0]), .dbg_state(dbg[0]));

  avr_progmem_boot #(.AW(AW), .WORDS(8), .FLASH_BASE(24'h012345), .DIV(3)) dut1 (
    .clock(clock), .reset(rst[1]), .pll_locked(pll[1]), .bus(bus1),
    .busy(busy[1]), .dbg_state(dbg[1]));

  assign bus0.pc = pc[0];
  assign bus0.spi_miso = miso[0];
  assign ir[0] = bus0.ir;
  assign locked[0] = bus0.locked;
  assign cs_n[0] = bus0.spi_cs_n;
  assign sck[0] = bus0.spi_sck;
  assign mosi[0] = bus0.spi_mosi;
  assign bus1.pc = pc[1];
  assign bus1.spi_miso = miso[1];
  assign ir[1] = bus1.ir;
  assign locked[1] = bus1.locked;
  assign cs_n[1] = bus1.spi_cs_n;
  assign sck[1] = bus1.spi_sck;
  assign mosi[1] = bus1.spi_mosi;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic int words_of(input int g);
    return (g == 0) ? 4 : 8;
  endfunction

  function automatic int div_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic logic [23:0] base_of(input int g);
    return (g == 0) ? 24'h000000 : 24'h012345;
  endfunction

  // Flash array: image bytes live at base_of(g); anything else reads as EE.
  function automatic logic [7:0] flash_byte(input int g, input logic [23:0] a);
    logic [23:0] off;
    off = a - base_of(g);
    if (off < 24'd16) return img[g][off[3:0]];
    return 8'hEE;
  endfunction

  // Reference: word i is little-endian bytes 2i (low) and 2i+1 (high).
  function automatic logic [15:0] exp_word(input int g, input int i);
    return {img[g][2*i+1], img[g][2*i]};
  endfunction

  // SPI flash model, observing pins once per clock (every SCK level spans >= 1 clock).
  always @(negedge clock) begin
    for (int g = 0; g < NI; g++) begin
      if (cs_n[g]) begin
        if (sck[g] !== 1'b0) sck_bad[g]++;
      end else if (cs_prev[g]) begin
        rises[g] = 0;
        cmd[g] = '0;
        cs_falls[g]++;
        lvl_len[g] = 1;
      end else begin
        if (sck[g] != sck_prev[g]) begin
          if (lvl_len[g] != div_of(g)) lvl_bad[g]++;
          lvl_len[g] = 1;
          if (sck[g]) begin
            if (rises[g] < 32) cmd[g] = {cmd[g][30:0], mosi[g]};
            rises[g]++;
          end else if (rises[g] >= 32) begin
            d_bit = rises[g] - 32;
            fbyte = flash_byte(g, cmd[g][23:0] + 24'(d_bit / 8));
            miso[g] = fbyte[7 - (d_bit % 8)];
          end
        end else begin
          lvl_len[g]++;
        end
        if (!sck[g] && rises[g] >= 32 && mosi[g]) mosi_bad[g]++;
      end
      cs_prev[g] = cs_n[g];
      sck_prev[g] = sck[g];
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_locks(input logic [NI-1:0] which, input int budget);
    logic [NI-1:0] done;
    int bad;
    done = ~which;
    bad = 0;
    for (int i = 0; i < budget && done != '1; i++) begin
      for (int g = 0; g < NI; g++) begin
        if (!done[g]) begin
          if (locked[g]) begin
            done[g] = 1'b1;
            chk($sformatf("lock_sck_rises%0d", g), rises[g], 32 + 16 * words_of(g));
          end else begin
            if (ir[g] !== 16'h0000) bad++;
            pc[g] = 16'($urandom);
          end
        end
      end
      if (done != '1) step();
    end
    chk("ir_nop_during_load", bad, 0);
    for (int g = 0; g < NI; g++)
      if (which[g]) chk($sformatf("lock_timeout%0d", g), done[g], 1);
  endtask

  task automatic wait_rises(input int g, input int n, input int budget);
    int i;
    for (i = 0; i < budget && rises[g] < n; i++) step();
    chk($sformatf("rise_timeout%0d", g), (rises[g] >= n), 1);
  endtask

  task automatic verify_mem(input int g, input int n);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = $urandom_range(0, words_of(g) - 1);
      pc[g] = {2'($urandom), 14'(idx)};
      step();
      chk($sformatf("fetch%0d_w%0d", g, idx), ir[g], exp_word(g, idx));
    end
  endtask

  task automatic post_load_checks();
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("mosi_cmd%0d", g), cmd[g], {8'h03, base_of(g)});
      chk($sformatf("sck_level_len%0d", g), lvl_bad[g], 0);
      chk($sformatf("mosi_zero_in_data%0d", g), mosi_bad[g], 0);
      chk($sformatf("sck_idle_low%0d", g), sck_bad[g], 0);
      chk($sformatf("busy_done%0d", g), busy[g], 0);
    end
  endtask

  initial begin
    vec_t vecs [7];
    logic [7:0] t0 [8];
    int first [NI];
    int bad;
    int falls;

    vecs[0] = '{16'h0000, 16'h940C};
    vecs[1] = '{16'h0001, 16'h1234};
    vecs[2] = '{16'h0002, 16'hCFFF};
    vecs[3] = '{16'h0003, 16'h0000};
    vecs[4] = '{16'hC001, 16'h1234};
    vecs[5] = '{16'h4002, 16'hCFFF};
    vecs[6] = '{16'h8000, 16'h940C};
    t0 = '{8'h0C, 8'h94, 8'h34, 8'h12, 8'hFF, 8'hCF, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) begin
      img[0][i] = (i < 8) ? t0[i] : 8'h00;
      img[1][i] = 8'($urandom);
    end
    for (int g = 0; g < NI; g++) begin
      rises[g] = 0; lvl_len[g] = 0; lvl_bad[g] = 0; mosi_bad[g] = 0;
      sck_bad[g] = 0; cs_falls[g] = 0; cmd[g] = '0;
    end
    miso = '0;
    rst = '1;
    pll = '0;
    pc = '0;
    repeat (3) step();

    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_ir%0d", g), ir[g], 16'h0000);
      chk($sformatf("rst_locked%0d", g), locked[g], 0);
      chk($sformatf("rst_cs_n%0d", g), cs_n[g], 1);
      chk($sformatf("rst_sck%0d", g), sck[g], 0);
      chk($sformatf("rst_mosi%0d", g), mosi[g], 0);
      chk($sformatf("rst_busy%0d", g), busy[g], 0);
    end
    rst = '0;

    // No flash activity while the clock source is unlocked.
    bad = 0;
    repeat (100) begin
      step();
      if (cs_n !== 2'b11 || sck !== 2'b00 || busy !== 2'b00) bad++;
    end
    chk("idle_without_pll", bad, 0);

    // CS stays high for 2*DIV clocks after pll_locked is seen, asserts on the next.
    pll = '1;
    first[0] = -1;
    first[1] = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      for (int g = 0; g < NI; g++)
        if (first[g] < 0 && !cs_n[g]) first[g] = k;
    end
    chk("guard0", first[0], 2 * div_of(0) + 1);
    chk("guard1", first[1], 2 * div_of(1) + 1);

    wait_locks(2'b11, 4000);
    post_load_checks();

    for (int i = 0; i < 7; i++) begin
      pc[0] = vecs[i].pc;
      step();
      chk($sformatf("vec%0d_pc%0h", i, vecs[i].pc), ir[0], vecs[i].exp);
    end

    verify_mem(0, 16);
    verify_mem(1, 24);

    // One-clock pll drop in DONE: locked follows combinationally, no reload.
    falls = cs_falls[0];
    pll[0] = 1'b0;
    #1;
    chk("lock_drop", locked[0], 0);
    step();
    pll[0] = 1'b1;
    #1;
    chk("lock_back", locked[0], 1);
    repeat (6) step();
    chk("no_cs_after_drop", cs_falls[0], falls);
    chk("cs_high_done", cs_n[0], 1);
    chk("state_done", dbg[0], 2'd3);
    pc[0] = 16'hC001;
    step();
    chk("fetch_after_drop", ir[0], 16'h1234);

    // Reset in the middle of the copy, then a full reload of a fresh image.
    for (int i = 0; i < 8; i++) img[0][i] = 8'($urandom);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    wait_rises(0, 40, 500);
    rst[0] = 1'b1;
    step();
    chk("midrst_cs_n", cs_n[0], 1);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_locked", locked[0], 0);
    rst[0] = 1'b0;
    falls = cs_falls[0];
    wait_locks(2'b01, 2000);
    chk("reload_one_cs", cs_falls[0], falls + 1);
    chk("reload_cmd", cmd[0], 32'h03000000);
    verify_mem(0, 12);

    // pll loss during DATA aborts; reload once it returns.
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    wait_rises(1, 50, 2000);
    pll[1] = 1'b0;
    step();
    chk("pll_abort_cs_n", cs_n[1], 1);
    chk("pll_abort_busy", busy[1], 0);
    chk("pll_abort_locked", locked[1], 0);
    for (int i = 0; i < 16; i++) img[1][i] = 8'($urandom);
    falls = cs_falls[1];
    repeat (10) step();
    chk("no_restart_unlocked", cs_falls[1], falls);
    pll[1] = 1'b1;
    wait_locks(2'b10, 4000);
    chk("reload_cmd1", cmd[1], 32'h03012345);
    post_load_checks();
    verify_mem(1, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
